vx_fpu_fflags_accum: RTL and testbench

- Receiving end of the FPU exception-flag path: takes per-lane fflags_t results from FPU writeback, ORs them across active lanes and accumulates them into per-warp sticky fflags.
- Serves the CSR unit's fflags/fcsr read, write, set and clear accesses.
- Sits between FPU commit and the CSR unit. Provides a sweep state machine that clears all warps on a command.

---
 rtl/vx_fpu_fflags_accum_pkg.sv | 43 ++++
 rtl/vx_fpu_fflags_accum_lane_merge.sv | 27 ++
 rtl/vx_fpu_fflags_accum.sv | 165 ++++++++++++++++
 tb/tb_vx_fpu_fflags_accum.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_fpu_fflags_accum_pkg.sv
// FPU exception-flag types shared by the fflags accumulator.
// fflags_t bit order: NV DZ OF UF NX (NV in the MSB).
package VX_fpu_types;

  localparam int FFLAGS_BITS = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    FFL_READ  = 2'd0,
    FFL_WRITE = 2'd1,
    FFL_SET   = 2'd2,
    FFL_CLEAR = 2'd3
  } fflags_csr_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_e;

  // New sticky value produced by a CSR access on top of eff.
  function automatic fflags_t fflags_csr_apply(
    input fflags_csr_op_t op,
    input fflags_t        eff,
    input fflags_t        wd
  );
    fflags_t r;
    unique case (op)
      FFL_READ:  r = eff;
      FFL_WRITE: r = wd;
      FFL_SET:   r = fflags_t'(eff | wd);
      FFL_CLEAR: r = fflags_t'(eff & ~wd);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vx_fpu_fflags_accum_lane_merge.sv
// vx_fflags_lane_merge: OR-reduce of the masked lanes into one fflags_t.
// Used for commit merging and for the stage-to-CSR forward.
module vx_fflags_lane_merge
  import VX_fpu_types::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]             tmask_i,
  input  logic [NUM_LANES*FFLAGS_BITS-1:0] fflags_i,
  output fflags_t                          merged_o
);

  logic [FFLAGS_BITS-1:0] acc;

  // OR together every lane whose mask bit is set.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tmask_i[i]) begin
        acc = acc | fflags_i[i*FFLAGS_BITS +: FFLAGS_BITS];
      end
    end
  end

  assign merged_o = fflags_t'(acc);

endmodule

// File: rtl/vx_fpu_fflags_accum.sv
// Per-warp sticky fflags: FPU commit merge, CSR access, clear sweep.
// Optional FPU_FFLAGS_PERF_EN adds per-flag commit event counters.
module vx_fpu_fflags_accum
  import VX_fpu_types::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             commit_valid,
  output logic                             commit_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]     commit_wid,
  input  logic [NUM_LANES-1:0]             commit_tmask,
  input  logic [NUM_LANES*FFLAGS_BITS-1:0] commit_fflags,
  input  logic                             csr_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]     csr_wid,
  input  logic [1:0]                       csr_op,
  input  logic [FFLAGS_BITS-1:0]           csr_wdata,
  output logic [FFLAGS_BITS-1:0]           csr_rdata,
  input  logic                             clear_all,
  output logic                             busy
`ifdef FPU_FFLAGS_PERF_EN
  ,
  output logic [5*32-1:0]                  perf_flag_events
`endif
);

  localparam int WW = $clog2(NUM_WARPS);
  localparam logic [WW-1:0] LAST_IDX = WW'(NUM_WARPS - 1);

  sweep_state_e state_q, state_d;
  logic [WW-1:0] idx_q, idx_d;

  logic          stage_valid_q;
  logic [WW-1:0] stage_wid_q;
  fflags_t       stage_flags_q;

  fflags_t sticky_q [NUM_WARPS];
  fflags_t sticky_d [NUM_WARPS];

  logic [FFLAGS_BITS-1:0] csr_rdata_q;

  fflags_t commit_merged;
  fflags_t csr_eff;
  logic    accept;
  logic    fwd_hit;

  assign commit_ready = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_SWEEP);
  assign accept       = commit_valid && commit_ready;
  assign csr_rdata    = csr_rdata_q;

  assign fwd_hit = stage_valid_q && (stage_wid_q == csr_wid);

  vx_fflags_lane_merge #(
    .NUM_LANES (NUM_LANES)
  ) u_commit_merge (
    .tmask_i  (commit_tmask),
    .fflags_i (commit_fflags),
    .merged_o (commit_merged)
  );

  // Lane 0 is the sticky value, lane 1 the pending stage entry.
  vx_fflags_lane_merge #(
    .NUM_LANES (2)
  ) u_fwd_merge (
    .tmask_i  ({fwd_hit, 1'b1}),
    .fflags_i ({stage_flags_q, sticky_q[csr_wid]}),
    .merged_o (csr_eff)
  );

  // Sweep FSM: walk every warp once, then return to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_all) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // Sticky update order: stage apply, then CSR, then sweep clear.
  always_comb begin
    sticky_d = sticky_q;
    if (stage_valid_q) begin
      sticky_d[stage_wid_q] =
        fflags_t'(sticky_q[stage_wid_q] | stage_flags_q);
    end
    if (csr_valid) begin
      sticky_d[csr_wid] = fflags_csr_apply(
        fflags_csr_op_t'(csr_op), csr_eff, fflags_t'(csr_wdata));
    end
    if (state_q == ST_SWEEP) begin
      sticky_d[idx_q] = '0;
    end
  end

  // State, stage and sticky registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      stage_valid_q <= 1'b0;
      stage_wid_q   <= '0;
      stage_flags_q <= '0;
      csr_rdata_q   <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        sticky_q[w] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_valid_q <= accept;
      if (accept) begin
        stage_wid_q   <= commit_wid;
        stage_flags_q <= commit_merged;
      end
      if (csr_valid) begin
        csr_rdata_q <= csr_eff;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
        sticky_q[w] <= sticky_d[w];
      end
    end
  end

`ifdef FPU_FFLAGS_PERF_EN
  logic [31:0] perf_q [FFLAGS_BITS];
  logic [FFLAGS_BITS-1:0] merged_v;

  assign merged_v = commit_merged;

  // Count accepted commits per raised flag; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FFLAGS_BITS; i++) begin
        perf_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < FFLAGS_BITS; i++) begin
        if (merged_v[i]) begin
          perf_q[i] <= perf_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < FFLAGS_BITS; g++) begin : g_perf
    assign perf_flag_events[g*32 +: 32] = perf_q[g];
  end
`endif

endmodule

// File: tb/tb_vx_fpu_fflags_accum.sv
// Self-checking bench for vx_fpu_fflags_accum.
// Random traffic is compared against a per-warp flag model.
module tb_vx_fpu_fflags_accum;

  logic        clk;
  logic        reset;
  logic        commit_valid;
  logic        commit_ready;
  logic [1:0]  commit_wid;
  logic [3:0]  commit_tmask;
  logic [19:0] commit_fflags;
  logic        csr_valid;
  logic [1:0]  csr_wid;
  logic [1:0]  csr_op;
  logic [4:0]  csr_wdata;
  logic [4:0]  csr_rdata;
  logic        clear_all;
  logic        busy;
`ifdef FPU_FFLAGS_PERF_EN
  logic [159:0] perf_flag_events;
`endif

  int checks;
  int failures;

  // Reference model state.
  logic [4:0] m_st [4];
  logic       m_sv;
  logic [1:0] m_swid;
  logic [4:0] m_sf;
  logic       m_sweep;
  int         m_idx;
  logic [4:0] m_rd;

  vx_fpu_fflags_accum #(
    .NUM_WARPS (4),
    .NUM_LANES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_wid    (commit_wid),
    .commit_tmask  (commit_tmask),
    .commit_fflags (commit_fflags),
    .csr_valid     (csr_valid),
    .csr_wid       (csr_wid),
    .csr_op        (csr_op),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .clear_all     (clear_all),
    .busy          (busy)
`ifdef FPU_FFLAGS_PERF_EN
    ,
    .perf_flag_events (perf_flag_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int w = 0; w < 4; w++) m_st[w] = 5'd0;
    m_sv = 1'b0;
    m_swid = 2'd0;
    m_sf = 5'd0;
    m_sweep = 1'b0;
    m_idx = 0;
    m_rd = 5'd0;
  endtask

  // One clock: update the model, drive the DUT, advance past the edge.
  task automatic drive_cycle(
    input logic        cv,
    input logic [1:0]  cw,
    input logic [3:0]  tm,
    input logic [19:0] cf,
    input logic        sv,
    input logic [1:0]  sw,
    input logic [1:0]  op,
    input logic [4:0]  wd,
    input logic        clr
  );
    logic [4:0] eff;
    logic [4:0] mrg;
    logic       rdy;
    rdy = !m_sweep;
    eff = m_st[sw];
    if (m_sv && m_swid == sw) eff = eff | m_sf;
    if (m_sv) m_st[m_swid] = m_st[m_swid] | m_sf;
    if (sv) begin
      case (op)
        2'd0: m_st[sw] = eff;
        2'd1: m_st[sw] = wd;
        2'd2: m_st[sw] = eff | wd;
        default: m_st[sw] = eff & ~wd;
      endcase
      m_rd = eff;
    end
    if (m_sweep) begin
      m_st[m_idx] = 5'd0;
      if (m_idx == 3) m_sweep = 1'b0;
      else m_idx = m_idx + 1;
    end else if (clr) begin
      m_sweep = 1'b1;
      m_idx = 0;
    end
    mrg = 5'd0;
    for (int i = 0; i < 4; i++) begin
      if (tm[i]) mrg = mrg | cf[i*5 +: 5];
    end
    m_sv = cv && rdy;
    m_swid = cw;
    m_sf = mrg;

    commit_valid  = cv;
    commit_wid    = cw;
    commit_tmask  = tm;
    commit_fflags = cf;
    csr_valid     = sv;
    csr_wid       = sw;
    csr_op        = op;
    csr_wdata     = wd;
    clear_all     = clr;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    csr_valid    = 1'b0;
    clear_all    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic csr(
    input logic [1:0] w,
    input logic [1:0] op,
    input logic [4:0] wd
  );
    drive_cycle(0, 0, 0, 0, 1, w, op, wd, 0);
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b ready=%b exp 0/1",
               busy, commit_ready);
    end
    checks++;
    if (csr_rdata !== 5'd0) begin
      failures++;
      $display("FAIL reset_rdata got=%b exp=00000", csr_rdata);
    end
    for (int w = 0; w < 4; w++) begin
      csr(2'(w), 2'd0, 5'd0);
      checks++;
      if (csr_rdata !== 5'd0) begin
        failures++;
        $display("FAIL reset_read_w%0d got=%b exp=00000", w, csr_rdata);
      end
    end
  endtask

  task automatic test_commit_merge();
    // lane0=NV lane1=DZ lane2=OF lane3=NX
    drive_cycle(1, 2'd1, 4'b0101,
                {5'b00001, 5'b00100, 5'b01000, 5'b10000},
                0, 0, 0, 0, 0);
    idle(1);
    csr(2'd1, 2'd0, 5'd0);
    checks++;
    if (csr_rdata !== 5'b10100) begin
      failures++;
      $display("FAIL merge_w1 got=%b exp=10100", csr_rdata);
    end
    for (int w = 0; w < 4; w++) begin
      if (w != 1) begin
        csr(2'(w), 2'd0, 5'd0);
        checks++;
        if (csr_rdata !== 5'd0) begin
          failures++;
          $display("FAIL merge_other_w%0d got=%b exp=00000",
                   w, csr_rdata);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    drive_cycle(1, 2'd2, 4'b0001, 20'h00001, 0, 0, 0, 0, 0);
    csr(2'd2, 2'd0, 5'd0);
    checks++;
    if (csr_rdata !== 5'b00001) begin
      failures++;
      $display("FAIL fwd_read got=%b exp=00001", csr_rdata);
    end
    drive_cycle(1, 2'd3, 4'b0001, 20'h00001, 0, 0, 0, 0, 0);
    csr(2'd3, 2'd2, 5'b01000);
    checks++;
    if (csr_rdata !== 5'b00001) begin
      failures++;
      $display("FAIL fwd_set_rdata got=%b exp=00001", csr_rdata);
    end
    csr(2'd3, 2'd0, 5'd0);
    checks++;
    if (csr_rdata !== 5'b01001) begin
      failures++;
      $display("FAIL fwd_set_sticky got=%b exp=01001", csr_rdata);
    end
  endtask

  task automatic test_csr_ops();
    csr(2'd0, 2'd1, 5'b11111);
    csr(2'd0, 2'd3, 5'b10001);
    checks++;
    if (csr_rdata !== 5'b11111) begin
      failures++;
      $display("FAIL clear_rdata got=%b exp=11111", csr_rdata);
    end
    csr(2'd0, 2'd0, 5'd0);
    checks++;
    if (csr_rdata !== 5'b01110) begin
      failures++;
      $display("FAIL clear_result got=%b exp=01110", csr_rdata);
    end
    csr(2'd0, 2'd1, 5'b00010);
    idle(2);
    checks++;
    if (csr_rdata !== 5'b01110) begin
      failures++;
      $display("FAIL rdata_hold got=%b exp=01110", csr_rdata);
    end
    csr(2'd0, 2'd0, 5'd0);
    checks++;
    if (csr_rdata !== 5'b00010) begin
      failures++;
      $display("FAIL write_result got=%b exp=00010", csr_rdata);
    end
  endtask

  task automatic test_clear_all();
    int cnt;
    for (int w = 0; w < 4; w++) csr(2'(w), 2'd1, 5'(5'b10000 | w));
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cnt = busy ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      // commits offered during the sweep must be refused
      drive_cycle(m_sweep, 2'(k), 4'b1111, 20'hfffff,
                  0, 0, 0, 0, k == 1);
      if (busy) cnt++;
      checks++;
      if (busy !== m_sweep || commit_ready !== !m_sweep) begin
        failures++;
        $display("FAIL sweep_k%0d busy=%b ready=%b exp_busy=%b",
                 k, busy, commit_ready, m_sweep);
      end
    end
    checks++;
    if (cnt != 4) begin
      failures++;
      $display("FAIL sweep_len got=%0d exp=4", cnt);
    end
    for (int w = 0; w < 4; w++) begin
      csr(2'(w), 2'd0, 5'd0);
      checks++;
      if (csr_rdata !== 5'd0) begin
        failures++;
        $display("FAIL swept_w%0d got=%b exp=00000", w, csr_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    csr(2'd1, 2'd1, 5'b11000);
    csr(2'd1, 2'd0, 5'd0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    checks++;
    if (busy !== 1'b1 || csr_rdata !== 5'b11000) begin
      failures++;
      $display("FAIL presweep busy=%b rdata=%b exp 1/11000",
               busy, csr_rdata);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || commit_ready !== 1'b1 ||
        csr_rdata !== 5'd0) begin
      failures++;
      $display("FAIL async_reset busy=%b ready=%b rdata=%b exp 0/1/0",
               busy, commit_ready, csr_rdata);
    end
    #2 reset = 1'b0;
    model_reset();
    csr(2'd1, 2'd0, 5'd0);
    checks++;
    if (csr_rdata !== 5'd0) begin
      failures++;
      $display("FAIL post_reset_w1 got=%b exp=00000", csr_rdata);
    end
  endtask

  task automatic test_random();
    logic sv;
    for (int n = 0; n < 400; n++) begin
      sv = 1'($urandom_range(0, 1));
      drive_cycle(1'($urandom_range(0, 1)), 2'($urandom),
                  4'($urandom), 20'($urandom),
                  sv, 2'($urandom), 2'($urandom), 5'($urandom),
                  $urandom_range(0, 39) == 0);
      checks++;
      if (csr_rdata !== m_rd || busy !== m_sweep ||
          commit_ready !== !m_sweep) begin
        failures++;
        $display("FAIL rand_%0d rdata=%b exp=%b busy=%b exp=%b",
                 n, csr_rdata, m_rd, busy, m_sweep);
      end
    end
    idle(5);
    for (int w = 0; w < 4; w++) begin
      csr(2'(w), 2'd0, 5'd0);
      checks++;
      if (csr_rdata !== m_rd) begin
        failures++;
        $display("FAIL rand_final_w%0d got=%b exp=%b",
                 w, csr_rdata, m_rd);
      end
    end
  endtask

`ifdef FPU_FFLAGS_PERF_EN
  task automatic test_perf();
    int exp_cnt [5];
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 2'(i), 4'b0001, 20'h00010, 0, 0, 0, 0, 0);
    end
    drive_cycle(1, 2'd3, 4'b0010, 20'h00100, 0, 0, 0, 0, 0);
    idle(1);
    exp_cnt = '{0, 0, 0, 1, 3};
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (perf_flag_events[b*32 +: 32] !== 32'(exp_cnt[b])) begin
        failures++;
        $display("FAIL perf_bit%0d got=%0d exp=%0d",
                 b, perf_flag_events[b*32 +: 32], exp_cnt[b]);
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(6);
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (perf_flag_events[b*32 +: 32] !== 32'(exp_cnt[b])) begin
        failures++;
        $display("FAIL perf_keep_bit%0d got=%0d exp=%0d",
                 b, perf_flag_events[b*32 +: 32], exp_cnt[b]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    commit_valid = 1'b0;
    commit_wid = 2'd0;
    commit_tmask = 4'd0;
    commit_fflags = 20'd0;
    csr_valid = 1'b0;
    csr_wid = 2'd0;
    csr_op = 2'd0;
    csr_wdata = 5'd0;
    clear_all = 1'b0;
    model_reset();
    #23 reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_commit_merge();
    test_forwarding();
    test_csr_ops();
    test_clear_all();
    test_reset_mid_sweep();
    test_random();
`ifdef FPU_FFLAGS_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
